dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter ACC_BITS, default 32, giving the FCW / phase-accumulator width.
REQ-002 The block SHALL have parameter DWELL_BITS, default 16, giving the dwell counter width.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request a sweep; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: terminate any sweep in progress.
REQ-007 The block SHALL have ports cfg_f_start, cfg_f_stop and cfg_f_step, input, ACC_BITS each: sweep start FCW, stop FCW and step size, all unsigned.
REQ-008 The block SHALL have port cfg_dwell, input, DWELL_BITS: dwell count D.
REQ-009 The block SHALL have port cfg_mode, input, 2 bits: 0 = single, 1 = repeat, 2 = up-down, 3 = reserved and treated as single.
REQ-010 The block SHALL have port cfg_dither, input, 1 bit: dither enable for the sweep.
REQ-011 The block SHALL have port FCW, output, ACC_BITS, registered: frequency control word to the DDS core.
REQ-012 The block SHALL have port fcw_valid, output, 1 bit: one-cycle pulse coincident with each new FCW value.
REQ-013 The block SHALL have port dither_ctrl, output, 1 bit: latched cfg_dither, routed to the DDS core.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse at normal sweep completion.
REQ-016 The block SHALL have port err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, DWELL, STEP and DONE.
REQ-018 In IDLE, start=1 SHALL latch all cfg_* inputs into shadow registers and move the FSM to LOAD; cfg_* changes after the latch SHALL have no effect until the next start.
REQ-019 If the latched f_stop < f_start, the FSM SHALL return to IDLE instead of LOAD, pulse err one cycle later, and leave FCW unchanged.
REQ-020 In LOAD, the block SHALL set FCW <= f_start, pulse fcw_valid, set dither_ctrl <= latched cfg_dither, load the dwell counter with D, set direction = up and go to DWELL.
REQ-021 Latency: with start sampled at edge n, FCW = f_start and fcw_valid = 1 SHALL be visible after edge n+2.
REQ-022 In DWELL, the counter SHALL decrement every cycle and the FSM SHALL go to STEP on the cycle it reads 0, so that every FCW value is held exactly D+2 cycles.
REQ-023 In STEP with direction up and FCW != f_stop, the block SHALL set FCW <= min(FCW + step, f_stop), with the sum computed at ACC_BITS+1 bits so that wrap-around clamps to f_stop; it SHALL pulse fcw_valid, reload the counter and go to DWELL.
REQ-024 In STEP with direction down and FCW != f_start, the block SHALL set FCW <= max(FCW - step, f_start), with borrow treated as clamp to f_start; it SHALL pulse fcw_valid, reload the counter and go to DWELL.
REQ-025 In STEP at FCW == f_stop with direction up, the mode SHALL decide the action:
- single: go to DONE.
- repeat: FCW <= f_start, fcw_valid, go to DWELL.
- up-down: set direction = down and apply REQ-024 in the same cycle.
REQ-026 In STEP at FCW == f_start with direction down (up-down mode only), the block SHALL set direction = up and apply REQ-023 in the same cycle.
REQ-027 If step == 0 or f_start == f_stop, the first STEP SHALL go to DONE in every mode, so no infinite sweep results.
REQ-028 DONE SHALL pulse done for one cycle and go to IDLE; FCW and dither_ctrl SHALL hold their last values.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with FCW held, no done pulse and no fcw_valid; abort SHALL take priority over every other transition.
REQ-030 abort in IDLE SHALL be ignored; start and abort asserted together in IDLE SHALL be treated as start.
REQ-031 start while busy SHALL be ignored, with no queueing and no err pulse.
REQ-032 fcw_valid SHALL never be high in two consecutive cycles unless D == 0 (in which case the FCW updates every 2 cycles, so it still cannot).

Reset
REQ-033 While RST=1, the block SHALL hold state = IDLE, FCW = 0, fcw_valid = 0, dither_ctrl = 0, busy = 0, done = 0, err = 0, counter = 0, direction = up and all shadow registers = 0.
REQ-034 RST asserted mid-sweep SHALL take effect asynchronously, with the outputs at REQ-033 values immediately; start SHALL be honoured from the first rising edge after RST deasserts.

Verification
REQ-035 The bench SHALL cover single mode: f_start=0x00133333, f_stop=0x00333333, step=0x00100000, D=3 -> FCW sequence 0x00133333, 0x00233333, 0x00333333, each held 5 cycles, 3 fcw_valid pulses, then done, busy low.
REQ-036 The bench SHALL cover clamp and wrap: f_start=0xFFFFFF00, f_stop=0xFFFFFFF0, step=0x80, D=0, single -> FCW 0xFFFFFF00, 0xFFFFFF80, 0xFFFFFFF0, then done; FCW never wraps to a small value.
REQ-037 The bench SHALL cover up-down: f_start=100, f_stop=300, step=100, D=1 -> FCW 100, 200, 300, 200, 100, 200, ..., continuing until abort, after which busy falls the next cycle and FCW holds.
REQ-038 The bench SHALL cover config errors: f_start=500, f_stop=400 -> err pulse, busy never rises, FCW unchanged; step=0 -> a single dwell at f_start, then done.
REQ-039 The bench SHALL cover restart rules: start pulsed mid-sweep -> ignored; repeat mode with f_start=0, f_stop=20, step=10 -> 0, 10, 20, 0, 10, ...; RST mid-DWELL -> all outputs 0 asynchronously.
REQ-040 The bench SHALL cover the dither path: cfg_dither=1 at start -> dither_ctrl=1 from LOAD onward and held after done; toggling cfg_dither mid-sweep -> no effect.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS core: steps an FCW from f_start to f_stop
// in single, repeat or up-down mode, holding each value for a programmable dwell.
module dds_sweep_ctrl #(
    parameter int unsigned ACC_BITS   = 32,
    parameter int unsigned DWELL_BITS = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ACC_BITS-1:0]   cfg_f_start,
    input  logic [ACC_BITS-1:0]   cfg_f_stop,
    input  logic [ACC_BITS-1:0]   cfg_f_step,
    input  logic [DWELL_BITS-1:0] cfg_dwell,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_dither,
    output logic [ACC_BITS-1:0]   FCW,
    output logic                  fcw_valid,
    output logic                  dither_ctrl,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {StIdle, StLoad, StDwell, StStep, StDone} state_e;

    localparam logic [1:0] ModeRepeat = 2'd1;
    localparam logic [1:0] ModeUpDown = 2'd2;

    state_e                state_q, state_d;
    logic [ACC_BITS-1:0]   f_start_q, f_start_d, f_stop_q, f_stop_d, f_step_q, f_step_d;
    logic [DWELL_BITS-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic                  dither_q, dither_d;
    logic [ACC_BITS-1:0]   cur_q, cur_d;
    logic                  upd_q, upd_d;
    logic                  dir_dn_q, dir_dn_d;
    logic [ACC_BITS-1:0]   fcw_q, fcw_d;
    logic                  fcw_valid_q, fcw_valid_d;
    logic                  dither_ctrl_q, dither_ctrl_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [ACC_BITS:0]     sum_w, diff_w;
    logic [ACC_BITS-1:0]   nxt_up, nxt_dn;

    // Extra bit catches both overflow past 2^ACC_BITS and borrow below zero.
    always_comb begin
        sum_w  = {1'b0, cur_q} + {1'b0, f_step_q};
        diff_w = {1'b0, cur_q} - {1'b0, f_step_q};
        nxt_up = (sum_w > {1'b0, f_stop_q}) ? f_stop_q : sum_w[ACC_BITS-1:0];
        nxt_dn = (diff_w[ACC_BITS] || (diff_w[ACC_BITS-1:0] < f_start_q)) ?
                 f_start_q : diff_w[ACC_BITS-1:0];
    end

    always_comb begin
        state_d       = state_q;
        f_start_d     = f_start_q;
        f_stop_d      = f_stop_q;
        f_step_d      = f_step_q;
        dwell_d       = dwell_q;
        mode_d        = mode_q;
        dither_d      = dither_q;
        cur_d         = cur_q;
        cnt_d         = cnt_q;
        dir_dn_d      = dir_dn_q;
        dither_ctrl_d = dither_ctrl_q;
        upd_d         = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        if (state_q == StIdle) begin
            if (start) begin
                f_start_d = cfg_f_start;
                f_stop_d  = cfg_f_stop;
                f_step_d  = cfg_f_step;
                dwell_d   = cfg_dwell;
                mode_d    = cfg_mode;
                dither_d  = cfg_dither;
                if (cfg_f_stop < cfg_f_start) err_d = 1'b1;
                else                          state_d = StLoad;
            end
        end else if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StLoad: begin
                    cur_d         = f_start_q;
                    upd_d         = 1'b1;
                    dither_ctrl_d = dither_q;
                    cnt_d         = dwell_q;
                    dir_dn_d      = 1'b0;
                    state_d       = StDwell;
                end
                StDwell: begin
                    if (cnt_q == '0) state_d = StStep;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                StStep: begin
                    cnt_d   = dwell_q;
                    upd_d   = 1'b1;
                    state_d = StDwell;
                    if ((f_step_q == '0) || (f_start_q == f_stop_q)) begin
                        upd_d   = 1'b0;
                        state_d = StDone;
                    end else if (!dir_dn_q) begin
                        if (cur_q != f_stop_q) begin
                            cur_d = nxt_up;
                        end else if (mode_q == ModeRepeat) begin
                            cur_d = f_start_q;
                        end else if (mode_q == ModeUpDown) begin
                            dir_dn_d = 1'b1;
                            cur_d    = nxt_dn;
                        end else begin
                            upd_d   = 1'b0;
                            state_d = StDone;
                        end
                    end else if (cur_q != f_start_q) begin
                        cur_d = nxt_dn;
                    end else begin
                        dir_dn_d = 1'b0;
                        cur_d    = nxt_up;
                    end
                end
                StDone: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d      = (state_d != StIdle);
        // Output stage: FCW/fcw_valid reach the core two edges after start.
        fcw_d       = cur_q;
        fcw_valid_d = upd_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= StIdle;
            f_start_q     <= '0;
            f_stop_q      <= '0;
            f_step_q      <= '0;
            dwell_q       <= '0;
            mode_q        <= '0;
            dither_q      <= 1'b0;
            cur_q         <= '0;
            upd_q         <= 1'b0;
            cnt_q         <= '0;
            dir_dn_q      <= 1'b0;
            fcw_q         <= '0;
            fcw_valid_q   <= 1'b0;
            dither_ctrl_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            f_start_q     <= f_start_d;
            f_stop_q      <= f_stop_d;
            f_step_q      <= f_step_d;
            dwell_q       <= dwell_d;
            mode_q        <= mode_d;
            dither_q      <= dither_d;
            cur_q         <= cur_d;
            upd_q         <= upd_d;
            cnt_q         <= cnt_d;
            dir_dn_q      <= dir_dn_d;
            fcw_q         <= fcw_d;
            fcw_valid_q   <= fcw_valid_d;
            dither_ctrl_q <= dither_ctrl_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign FCW         = fcw_q;
    assign fcw_valid   = fcw_valid_q;
    assign dither_ctrl = dither_ctrl_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: expected FCW values are queued per sweep
// and popped by a monitor on every fcw_valid, which also checks the dwell spacing.
module tb_dds_sweep_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_f_start = '0, cfg_f_stop = '0, cfg_f_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_dither = 1'b0;
    logic [31:0] FCW;
    logic        fcw_valid, dither_ctrl, busy, done, err;

    dds_sweep_ctrl #(.ACC_BITS(32), .DWELL_BITS(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
        .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_dither(cfg_dither),
        .FCW(FCW), .fcw_valid(fcw_valid), .dither_ctrl(dither_ctrl),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] sb_q[$];
    int          hold_exp = 0;
    bit          have_prev = 1'b0;
    int          prev_cyc = 0;
    int          valid_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard monitor: each fcw_valid pops one expected FCW.
    always @(posedge CLK) begin
        logic [31:0] exp_v;
        #1;
        if (!RST && fcw_valid) begin
            valid_cnt++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL fcw_unexpected: got FCW=%h, expected no update", FCW);
            end else begin
                exp_v = sb_q.pop_front();
                if (FCW !== exp_v) begin
                    bad++;
                    $display("FAIL fcw_value: got %h, expected %h", FCW, exp_v);
                end
            end
            if (have_prev) begin
                total++;
                if (cyc - prev_cyc != hold_exp) begin
                    bad++;
                    $display("FAIL fcw_hold: got %0d cycles, expected %0d", cyc - prev_cyc,
                             hold_exp);
                end
            end
            have_prev = 1'b1;
            prev_cyc  = cyc;
        end
    end

    task automatic start_sweep(input logic [31:0] fs, input logic [31:0] fe,
                               input logic [31:0] st, input logic [15:0] d,
                               input logic [1:0] m, input logic dith);
        @(negedge CLK);
        cfg_f_start = fs;
        cfg_f_stop  = fe;
        cfg_f_step  = st;
        cfg_dwell   = d;
        cfg_mode    = m;
        cfg_dither  = dith;
        have_prev   = 1'b0;
        hold_exp    = int'(d) + 2;
        start       = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(posedge CLK);
            #2;
            if (done) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_done: got no done pulse, expected one within %0d cycles", name,
                     bound);
        end else begin
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL %s_busy_at_done: got %b, expected 0", name, busy);
            end
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_sb_left: got %0d pending, expected 0", name, sb_q.size());
        end
    endtask

    task automatic wait_sb_empty(input int bound, input string name);
        int i = 0;
        while (sb_q.size() != 0 && i < bound) begin
            @(negedge CLK);
            i++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_sb_timeout: got %0d pending, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic abort_and_check(input string name);
        logic [31:0] held;
        bit          moved = 1'b0;
        abort = 1'b1;
        @(posedge CLK);
        #2 abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_abort_busy: got %b, expected 0", name, busy);
        end
        held = FCW;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #2;
            if (FCW !== held || done || busy) moved = 1'b1;
        end
        total++;
        if (moved) begin
            bad++;
            $display("FAIL %s_abort_hold: got FCW=%h busy=%b done=%b, expected FCW=%h idle",
                     name, FCW, busy, done, held);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({FCW, fcw_valid, dither_ctrl, busy, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got FCW=%h v=%b d=%b busy=%b done=%b err=%b, expected 0",
                     FCW, fcw_valid, dither_ctrl, busy, done, err);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_single_dither();
        int  v0;
        bit  late_busy = 1'b0;
        sb_q.push_back(32'h0013_3333);
        sb_q.push_back(32'h0023_3333);
        sb_q.push_back(32'h0033_3333);
        v0 = valid_cnt;
        start_sweep(32'h0013_3333, 32'h0033_3333, 32'h0010_0000, 16'd3, 2'd0, 1'b1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_busy: got %b, expected 1", busy);
        end
        @(posedge CLK);
        #2;
        total++;
        if (fcw_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_latency_early: got fcw_valid=%b, expected 0", fcw_valid);
        end
        @(posedge CLK);
        #2;
        total++;
        if (fcw_valid !== 1'b1 || FCW !== 32'h0013_3333 || dither_ctrl !== 1'b1) begin
            bad++;
            $display("FAIL single_latency: got v=%b FCW=%h dith=%b, expected 1 00133333 1",
                     fcw_valid, FCW, dither_ctrl);
        end
        // Mid-sweep config changes and a second start must have no effect.
        @(negedge CLK);
        cfg_dither = 1'b0;
        cfg_f_stop = 32'h0040_0000;
        start      = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done(60, "single");
        total++;
        if (FCW !== 32'h0033_3333 || dither_ctrl !== 1'b1 || valid_cnt - v0 != 3) begin
            bad++;
            $display("FAIL single_final: got FCW=%h dith=%b pulses=%0d, expected 00333333 1 3",
                     FCW, dither_ctrl, valid_cnt - v0);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #2;
            if (busy) late_busy = 1'b1;
        end
        total++;
        if (late_busy) begin
            bad++;
            $display("FAIL restart_ignored: got busy after done, expected idle");
        end
    endtask

    task automatic test_clamp();
        sb_q.push_back(32'hFFFF_FF00);
        sb_q.push_back(32'hFFFF_FF80);
        sb_q.push_back(32'hFFFF_FFF0);
        start_sweep(32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h0000_0080, 16'd0, 2'd0, 1'b0);
        wait_done(40, "clamp");
        total++;
        if (FCW !== 32'hFFFF_FFF0 || dither_ctrl !== 1'b0) begin
            bad++;
            $display("FAIL clamp_final: got FCW=%h dith=%b, expected fffffff0 0", FCW,
                     dither_ctrl);
        end
    endtask

    task automatic test_updown();
        logic [31:0] seq [7] = '{100, 200, 300, 200, 100, 200, 300};
        foreach (seq[i]) sb_q.push_back(seq[i]);
        start_sweep(32'd100, 32'd300, 32'd100, 16'd1, 2'd2, 1'b0);
        wait_sb_empty(100, "updown");
        abort_and_check("updown");
        total++;
        if (FCW !== 32'd300) begin
            bad++;
            $display("FAIL updown_held: got %0d, expected 300", FCW);
        end
    endtask

    task automatic test_errors();
        logic [31:0] prev = FCW;
        int          err_cnt = 0;
        bit          saw_busy = 1'b0;
        start_sweep(32'd500, 32'd400, 32'd10, 16'd1, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (err) err_cnt++;
            if (busy) saw_busy = 1'b1;
            @(posedge CLK);
            #2;
        end
        total++;
        if (err_cnt != 1 || saw_busy || FCW !== prev) begin
            bad++;
            $display("FAIL cfg_err: got err=%0d busy=%b FCW=%h, expected 1 0 %h", err_cnt,
                     saw_busy, FCW, prev);
        end
        sb_q.push_back(32'h0000_1000);
        start_sweep(32'h0000_1000, 32'h0000_2000, 32'd0, 16'd2, 2'd1, 1'b0);
        wait_done(30, "step0");
        total++;
        if (FCW !== 32'h0000_1000) begin
            bad++;
            $display("FAIL step0_final: got %h, expected 00001000", FCW);
        end
    endtask

    task automatic test_repeat();
        logic [31:0] seq [7] = '{0, 10, 20, 0, 10, 20, 0};
        foreach (seq[i]) sb_q.push_back(seq[i]);
        start_sweep(32'd0, 32'd20, 32'd10, 16'd2, 2'd1, 1'b0);
        wait_sb_empty(100, "repeat");
        abort_and_check("repeat");
    endtask

    task automatic test_rst_mid();
        sb_q.push_back(32'd100);
        start_sweep(32'd100, 32'd900, 32'd100, 16'd4, 2'd0, 1'b1);
        wait_sb_empty(20, "rstmid");
        @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        total++;
        if ({FCW, fcw_valid, dither_ctrl, busy, done, err} !== '0) begin
            bad++;
            $display("FAIL rst_async: got FCW=%h v=%b d=%b busy=%b done=%b err=%b, expected 0",
                     FCW, fcw_valid, dither_ctrl, busy, done, err);
        end
        @(negedge CLK);
        RST         = 1'b0;
        cfg_f_start = 32'd5;
        cfg_f_stop  = 32'd50;
        cfg_f_step  = 32'd5;
        cfg_dwell   = 16'd3;
        cfg_mode    = 2'd0;
        have_prev   = 1'b0;
        hold_exp    = 5;
        sb_q.push_back(32'd5);
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_restart: got busy=%b, expected 1", busy);
        end
        wait_sb_empty(20, "rstrestart");
        abort_and_check("rstrestart");
    endtask

    initial begin
        test_reset();
        test_single_dither();
        test_clamp();
        test_updown();
        test_errors();
        test_repeat();
        test_rst_mid();
        repeat (3) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
